psum_write_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single write port of the partial-sum buffer among the seven PE-row psum producers. It latches the operating mode and per-row packet quota on `start_conv` and grants one psum packet per cycle to an eligible row. Each granted packet is registered into a one-entry output stage toward the buffer. When every active row has delivered its quota and the output stage has drained, it signals completion.

---
 rtl/psum_write_arbiter_if.sv | 29 ++
 rtl/psum_write_arbiter.sv | 123 ++++++++++++
 tb/tb_psum_write_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_write_arbiter_if.sv
// rtl/psum_write_arbiter_if.sv - handshake bundle between PE rows, start control and psum buffer write port
interface psum_write_arbiter_if #(
   parameter int NUM_PE = 7,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 8
);
   logic                     start_conv;
   logic [1:0]               mode_in;
   logic [CNT_W-1:0]         pkt_per_row;
   logic [NUM_PE-1:0]        pe_psum_req;
   logic [NUM_PE*DATA_W-1:0] pe_psum_data;
   logic [NUM_PE-1:0]        psum_grant;
   logic                     buf_wr_valid;
   logic                     buf_wr_ready;
   logic [DATA_W-1:0]        buf_wr_data;
   logic [2:0]               buf_wr_row;
   logic                     busy;
   logic                     conv_done;

   modport master (
      input  start_conv, mode_in, pkt_per_row, pe_psum_req, pe_psum_data, buf_wr_ready,
      output psum_grant, buf_wr_valid, buf_wr_data, buf_wr_row, busy, conv_done
   );

   modport slave (
      output start_conv, mode_in, pkt_per_row, pe_psum_req, pe_psum_data, buf_wr_ready,
      input  psum_grant, buf_wr_valid, buf_wr_data, buf_wr_row, busy, conv_done
   );
endinterface

// File: rtl/psum_write_arbiter.sv
// rtl/psum_write_arbiter.sv - round-robin arbiter sharing the psum buffer write port among PE rows
module psum_write_arbiter #(
   parameter int NUM_PE = 7,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 8
) (
   input logic                  clk,
   input logic                  rst,
   psum_write_arbiter_if.master bus_if
);
   localparam int IDX_W = $clog2(NUM_PE);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t              state_q;
   logic [NUM_PE-1:0]   mask_q;
   logic [CNT_W-1:0]    quota_q;
   logic [CNT_W-1:0]    cnt_q [NUM_PE];
   logic [IDX_W-1:0]    ptr_q;
   logic                valid_q;
   logic [DATA_W-1:0]   data_q;
   logic [2:0]          row_q;
   logic                busy_q;
   logic                done_q;

   logic [NUM_PE-1:0]   eligible;
   logic [NUM_PE-1:0]   row_fin;
   logic                slot;
   logic                grant_found;
   logic [IDX_W-1:0]    grant_idx;
   logic                grant_vld;
   logic                all_fin;

   function automatic logic [NUM_PE-1:0] mode_mask(input logic [1:0] m);
      case (m)
         2'd1:    mode_mask = NUM_PE'(5'h1F);
         2'd2:    mode_mask = NUM_PE'(3'h7);
         default: mode_mask = '1;
      endcase
   endfunction

   assign slot      = !valid_q || bus_if.buf_wr_ready;
   assign grant_vld = (state_q == S_RUN) && slot && grant_found;
   assign all_fin   = &row_fin;

   // First eligible row after the pointer wins; pointer then parks on the winner.
   always_comb begin
      eligible    = '0;
      row_fin     = '0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         eligible[i] = bus_if.pe_psum_req[i] && mask_q[i] && (cnt_q[i] != quota_q);
      end
      for (int k = 1; k <= NUM_PE; k++) begin
         if (!grant_found && eligible[(int'(ptr_q) + k) % NUM_PE]) begin
            grant_found = 1'b1;
            grant_idx   = IDX_W'((int'(ptr_q) + k) % NUM_PE);
         end
      end
      // A row counts as finished if this cycle's grant brings it to quota.
      for (int i = 0; i < NUM_PE; i++) begin
         row_fin[i] = !mask_q[i] || (cnt_q[i] == quota_q) ||
                      (grant_vld && (grant_idx == IDX_W'(i)) && (cnt_q[i] + CNT_W'(1) == quota_q));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         mask_q  <= '0;
         quota_q <= '0;
         for (int i = 0; i < NUM_PE; i++) cnt_q[i] <= '0;
         ptr_q   <= IDX_W'(NUM_PE - 1);
         valid_q <= 1'b0;
         data_q  <= '0;
         row_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (grant_vld) begin
            valid_q            <= 1'b1;
            data_q             <= bus_if.pe_psum_data[int'(grant_idx)*DATA_W +: DATA_W];
            row_q              <= 3'(grant_idx);
            cnt_q[grant_idx]   <= cnt_q[grant_idx] + CNT_W'(1);
            ptr_q              <= grant_idx;
         end else if (bus_if.buf_wr_ready) begin
            valid_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (bus_if.start_conv) begin
                  mask_q  <= mode_mask(bus_if.mode_in);
                  quota_q <= bus_if.pkt_per_row;
                  for (int i = 0; i < NUM_PE; i++) cnt_q[i] <= '0;
                  ptr_q   <= IDX_W'(NUM_PE - 1);
                  busy_q  <= 1'b1;
                  state_q <= (bus_if.pkt_per_row == '0) ? S_DRAIN : S_RUN;
               end
            end
            S_RUN: begin
               if (all_fin) state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               if (!valid_q || bus_if.buf_wr_ready) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus_if.psum_grant   = grant_vld ? (NUM_PE'(1) << grant_idx) : '0;
   assign bus_if.buf_wr_valid = valid_q;
   assign bus_if.buf_wr_data  = data_q;
   assign bus_if.buf_wr_row   = row_q;
   assign bus_if.busy         = busy_q;
   assign bus_if.conv_done    = done_q;
endmodule

// File: tb/tb_psum_write_arbiter.sv
// tb/tb_psum_write_arbiter.sv - directed self-checking bench for psum_write_arbiter
module tb_psum_write_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   start_cyc = 0;
   int   errs = 0;
   int   checks = 0;

   psum_write_arbiter_if #(.NUM_PE(7), .DATA_W(16), .CNT_W(8)) bus_if ();

   psum_write_arbiter #(.NUM_PE(7), .DATA_W(16), .CNT_W(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int          g_rows[$];
   int          w_rows[$];
   logic [15:0] w_data[$];
   int          w_cyc[$];
   int          busy_cnt, done_cnt, stall_cnt, stall_viol, unstable, multi;
   logic        prev_stall;
   logic [15:0] prev_data;
   logic [2:0]  prev_row;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] pkt(input int t, input int i);
      return 16'((t << 8) | i);
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (bus_if.psum_grant != '0) begin
            int gi = 0;
            if (!$onehot(bus_if.psum_grant)) multi++;
            for (int i = 0; i < 7; i++) if (bus_if.psum_grant[i]) gi = i;
            g_rows.push_back(gi);
            if (bus_if.buf_wr_valid && !bus_if.buf_wr_ready) stall_viol++;
         end
         if (bus_if.buf_wr_valid && bus_if.buf_wr_ready) begin
            w_rows.push_back(int'(bus_if.buf_wr_row));
            w_data.push_back(bus_if.buf_wr_data);
            w_cyc.push_back(cyc);
         end
         if (bus_if.buf_wr_valid && !bus_if.buf_wr_ready) stall_cnt++;
         if (prev_stall && (!bus_if.buf_wr_valid || bus_if.buf_wr_data != prev_data ||
                            bus_if.buf_wr_row != prev_row)) unstable++;
         prev_stall = bus_if.buf_wr_valid && !bus_if.buf_wr_ready;
         prev_data  = bus_if.buf_wr_data;
         prev_row   = bus_if.buf_wr_row;
         if (bus_if.busy) busy_cnt++;
         if (bus_if.conv_done) done_cnt++;
      end
   end

   task automatic clear_mon();
      g_rows.delete(); w_rows.delete(); w_data.delete(); w_cyc.delete();
      busy_cnt = 0; done_cnt = 0; stall_cnt = 0; stall_viol = 0; unstable = 0;
   endtask

   task automatic set_data(input int t);
      for (int i = 0; i < 7; i++) bus_if.pe_psum_data[i*16 +: 16] = pkt(t, i);
   endtask

   task automatic start(input logic [1:0] m, input logic [7:0] q);
      @(posedge clk); #1;
      bus_if.mode_in     = m;
      bus_if.pkt_per_row = q;
      bus_if.start_conv  = 1'b1;
      start_cyc          = cyc;
      @(posedge clk); #1;
      bus_if.start_conv  = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int maxc, output int lat);
      bit seen = 1'b0;
      lat = -1;
      for (int i = 0; i < maxc && !seen; i++) begin
         @(negedge clk);
         if (bus_if.conv_done) begin
            seen = 1'b1;
            lat  = cyc - start_cyc;
         end
      end
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
   endtask

   int lat;
   int n5;

   initial begin
      multi = 0;
      bus_if.start_conv   = 1'b0;
      bus_if.mode_in      = 2'd0;
      bus_if.pkt_per_row  = 8'd0;
      bus_if.pe_psum_req  = '0;
      bus_if.pe_psum_data = '0;
      bus_if.buf_wr_ready = 1'b1;
      clear_mon();

      repeat (3) @(posedge clk);
      #1;
      chk("rst_grant", 32'(bus_if.psum_grant), 32'd0);
      chk("rst_valid", 32'(bus_if.buf_wr_valid), 32'd0);
      chk("rst_data",  32'(bus_if.buf_wr_data), 32'd0);
      chk("rst_row",   32'(bus_if.buf_wr_row), 32'd0);
      chk("rst_busy",  32'(bus_if.busy), 32'd0);
      chk("rst_done",  32'(bus_if.conv_done), 32'd0);
      rst = 1'b0;

      // all rows, quota 2, free-flowing buffer
      set_data(1);
      bus_if.pe_psum_req = 7'h7F;
      clear_mon();
      start(2'd0, 8'd2);
      wait_done("t1", 60, lat);
      repeat (2) @(posedge clk);
      #1;
      chk("t1_latency", 32'(lat), 32'd16);
      chk("t1_ngrant", 32'(g_rows.size()), 32'd14);
      chk("t1_nwrite", 32'(w_rows.size()), 32'd14);
      for (int k = 0; k < 14 && k < g_rows.size() && k < w_rows.size(); k++) begin
         chk($sformatf("t1_grant%0d", k), 32'(g_rows[k]), 32'(k % 7));
         chk($sformatf("t1_wrow%0d", k), 32'(w_rows[k]), 32'(k % 7));
         chk($sformatf("t1_wdata%0d", k), 32'(w_data[k]), 32'(pkt(1, k % 7)));
      end
      chk("t1_done_cnt", 32'(done_cnt), 32'd1);
      chk("t1_busy_cycles", 32'(busy_cnt), 32'd15);

      // mode 2: row 5 inactive, row 0 alone first, rows 1-2 later to finish
      set_data(2);
      bus_if.pe_psum_req = 7'b0100001;
      clear_mon();
      start(2'd2, 8'd3);
      repeat (8) @(posedge clk);
      #1;
      chk("t2_ngrant_a", 32'(g_rows.size()), 32'd3);
      for (int k = 0; k < 3 && k < g_rows.size(); k++)
         chk($sformatf("t2_grant%0d", k), 32'(g_rows[k]), 32'd0);
      chk("t2_busy_mid", 32'(bus_if.busy), 32'd1);
      chk("t2_done_mid", 32'(done_cnt), 32'd0);
      bus_if.pe_psum_req = 7'b0100111;
      wait_done("t2", 40, lat);
      repeat (2) @(posedge clk);
      #1;
      chk("t2_ngrant_b", 32'(g_rows.size()), 32'd9);
      for (int k = 3; k < 9 && k < g_rows.size(); k++)
         chk($sformatf("t2_grant%0d", k), 32'(g_rows[k]), 32'((k % 2 == 1) ? 1 : 2));
      n5 = 0;
      foreach (g_rows[k]) if (g_rows[k] == 5) n5++;
      chk("t2_row5_grants", 32'(n5), 32'd0);
      chk("t2_grant_idle", 32'(bus_if.psum_grant), 32'd0);
      chk("t2_done_cnt", 32'(done_cnt), 32'd1);

      // backpressure: mode 1, quota 1, ready low for 4 cycles after first valid
      set_data(3);
      bus_if.pe_psum_req = 7'h7F;
      bus_if.buf_wr_ready = 1'b1;
      clear_mon();
      start(2'd1, 8'd1);
      begin
         bit got_v = 1'b0;
         for (int i = 0; i < 10 && !got_v; i++) begin
            @(posedge clk); #1;
            if (bus_if.buf_wr_valid) got_v = 1'b1;
         end
         chk("t3_first_valid", 32'(got_v), 32'd1);
      end
      bus_if.buf_wr_ready = 1'b0;
      chk("t3_hold_row", 32'(bus_if.buf_wr_row), 32'd0);
      chk("t3_hold_data", 32'(bus_if.buf_wr_data), 32'(pkt(3, 0)));
      repeat (4) @(posedge clk);
      #1;
      bus_if.buf_wr_ready = 1'b1;
      wait_done("t3", 30, lat);
      repeat (2) @(posedge clk);
      #1;
      chk("t3_ngrant", 32'(g_rows.size()), 32'd5);
      chk("t3_nwrite", 32'(w_rows.size()), 32'd5);
      for (int k = 0; k < 5 && k < w_rows.size() && k < g_rows.size(); k++) begin
         chk($sformatf("t3_grant%0d", k), 32'(g_rows[k]), 32'(k));
         chk($sformatf("t3_wrow%0d", k), 32'(w_rows[k]), 32'(k));
         chk($sformatf("t3_wdata%0d", k), 32'(w_data[k]), 32'(pkt(3, k)));
      end
      for (int k = 1; k < w_cyc.size(); k++)
         chk($sformatf("t3_b2b%0d", k), 32'(w_cyc[k] - w_cyc[k-1]), 32'd1);
      chk("t3_stall_cycles", 32'(stall_cnt), 32'd4);
      chk("t3_stall_grants", 32'(stall_viol), 32'd0);
      chk("t3_unstable", 32'(unstable), 32'd0);
      chk("t3_done_cnt", 32'(done_cnt), 32'd1);

      // fairness: row 1 reaches quota first, then rows 1 and 3 compete
      set_data(4);
      bus_if.pe_psum_req = 7'b0000010;
      clear_mon();
      start(2'd0, 8'd4);
      repeat (6) @(posedge clk);
      #1;
      chk("t4_row1_grants", 32'(g_rows.size()), 32'd4);
      bus_if.pe_psum_req = 7'b0001010;
      repeat (8) @(posedge clk);
      #1;
      chk("t4_ngrant", 32'(g_rows.size()), 32'd8);
      for (int k = 4; k < 8 && k < g_rows.size(); k++)
         chk($sformatf("t4_grant%0d", k), 32'(g_rows[k]), 32'd3);
      chk("t4_both_at_quota", 32'(bus_if.psum_grant), 32'd0);
      bus_if.pe_psum_req = 7'h7F;
      wait_done("t4", 60, lat);
      repeat (2) @(posedge clk);
      #1;
      chk("t4_total", 32'(g_rows.size()), 32'd28);
      chk("t4_done_cnt", 32'(done_cnt), 32'd1);

      // quota 0
      clear_mon();
      start(2'd0, 8'd0);
      wait_done("t5", 10, lat);
      repeat (2) @(posedge clk);
      #1;
      chk("t5_latency", 32'(lat), 32'd2);
      chk("t5_ngrant", 32'(g_rows.size()), 32'd0);
      chk("t5_nwrite", 32'(w_rows.size()), 32'd0);
      chk("t5_done_cnt", 32'(done_cnt), 32'd1);

      // reset mid-run with a packet in the output stage
      set_data(6);
      clear_mon();
      start(2'd0, 8'd2);
      repeat (3) @(posedge clk);
      #3;
      chk("t6_pre_valid", 32'(bus_if.buf_wr_valid), 32'd1);
      chk("t6_pre_row", 32'(bus_if.buf_wr_row), 32'd2);
      rst = 1'b1;
      #1;
      chk("t6_grant", 32'(bus_if.psum_grant), 32'd0);
      chk("t6_valid", 32'(bus_if.buf_wr_valid), 32'd0);
      chk("t6_data", 32'(bus_if.buf_wr_data), 32'd0);
      chk("t6_row", 32'(bus_if.buf_wr_row), 32'd0);
      chk("t6_busy", 32'(bus_if.busy), 32'd0);
      chk("t6_done", 32'(bus_if.conv_done), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      clear_mon();
      start(2'd0, 8'd1);
      wait_done("t6", 30, lat);
      repeat (2) @(posedge clk);
      #1;
      chk("t6_ngrant", 32'(g_rows.size()), 32'd7);
      for (int k = 0; k < 7 && k < g_rows.size(); k++)
         chk($sformatf("t6_grant%0d", k), 32'(g_rows[k]), 32'(k));
      chk("t6_done_cnt", 32'(done_cnt), 32'd1);
      chk("onehot_grants", 32'(multi), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
